// File: rtl/exe_muldiv_unit_pkg.sv
// Shared op codes, FSM state codes and op-decode helpers for the RV64M multiply/divide unit.
package exe_muldiv_unit_pkg;

    typedef enum logic [3:0] {
        MD_OP_MUL    = 4'd0,
        MD_OP_MULH   = 4'd1,
        MD_OP_MULHSU = 4'd2,
        MD_OP_MULHU  = 4'd3,
        MD_OP_DIV    = 4'd4,
        MD_OP_DIVU   = 4'd5,
        MD_OP_REM    = 4'd6,
        MD_OP_REMU   = 4'd7,
        MD_OP_MULW   = 4'd8,
        MD_OP_DIVW   = 4'd9,
        MD_OP_DIVUW  = 4'd10,
        MD_OP_REMW   = 4'd11,
        MD_OP_REMUW  = 4'd12
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_DONE = 2'd2
    } md_state_e;

    function automatic logic op_is_w(input logic [3:0] op);
        return op inside {MD_OP_MULW, MD_OP_DIVW, MD_OP_DIVUW, MD_OP_REMW, MD_OP_REMUW};
    endfunction

    function automatic logic op_is_mul(input logic [3:0] op);
        return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU, MD_OP_MULW};
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU,
                          MD_OP_DIVW, MD_OP_DIVUW, MD_OP_REMW, MD_OP_REMUW};
    endfunction

    function automatic logic op_is_rem(input logic [3:0] op);
        return op inside {MD_OP_REM, MD_OP_REMU, MD_OP_REMW, MD_OP_REMUW};
    endfunction

    // MULW is handled unsigned: the low 32 product bits do not depend on signedness.
    function automatic logic op_rs1_signed(input logic [3:0] op);
        return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM,
                          MD_OP_DIVW, MD_OP_REMW};
    endfunction

    function automatic logic op_rs2_signed(input logic [3:0] op);
        return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM, MD_OP_DIVW, MD_OP_REMW};
    endfunction

endpackage

// File: rtl/md_iter_divider.sv
// Radix-2 restoring divider on magnitudes plus the shared iteration counter.
module md_iter_divider
    import exe_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            w,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dsr_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] limit_q;

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_q};
    end

    assign last      = (cnt_q == limit_q);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (step && !last) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // W dividends are pre-shifted so their bit 31 is the first bit consumed.
    always_ff @(posedge clk) begin
        if (start) begin
            quo_q   <= w ? (dividend << (XLEN - 32)) : dividend;
            dsr_q   <= divisor;
            rem_q   <= '0;
            limit_q <= w ? CNT_W'(32) : CNT_W'(XLEN);
        end else if (step && !last) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit; optional MULDIV_EARLY_OUT_EN shortcuts trivial operands.
module exe_muldiv_unit
    import exe_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    output md_state_e       dbg_state
);

    // Handshake: a transfer happens on a posedge where valid && ready; out_result is held
    // unchanged while out_valid && !out_ready, and flush discards whatever is in flight.
    md_state_e         state, state_next;
    logic              accept, step, div_last, in_w, div_zero, early_now;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_ext, rs2_ext, rs1_mag, rs2_mag;
    logic [3:0]        op_q;
    logic              s1_q, s2_q, div_zero_q, early_q;
    logic [XLEN-1:0]   mcand_q, quo, rem, quo_s, rem_s, res_next;
    logic [2*XLEN-1:0] acc_q, prod;
    logic [XLEN:0]     mul_sum;

    assign accept = (state == MD_ST_IDLE) && in_valid && !flush;
    assign step   = (state == MD_ST_CALC) && !div_last && !early_q;

    always_comb begin
        in_w    = op_is_w(in_op);
        rs1_ext = in_rs1;
        rs2_ext = in_rs2;
        if (in_w) begin
            if (op_rs1_signed(in_op)) rs1_ext = XLEN'($signed(in_rs1[31:0]));
            else                      rs1_ext = XLEN'(in_rs1[31:0]);
            if (op_rs2_signed(in_op)) rs2_ext = XLEN'($signed(in_rs2[31:0]));
            else                      rs2_ext = XLEN'(in_rs2[31:0]);
        end
        rs1_neg  = op_rs1_signed(in_op) && rs1_ext[XLEN-1];
        rs2_neg  = op_rs2_signed(in_op) && rs2_ext[XLEN-1];
        rs1_mag  = rs1_neg ? -rs1_ext : rs1_ext;
        rs2_mag  = rs2_neg ? -rs2_ext : rs2_ext;
        div_zero = (rs2_ext == '0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit, early_hit_q, ovf;
    logic [XLEN-1:0] early_res, early_res_q, rs1_wfix, min_mag;

    always_comb begin
        rs1_wfix = in_rs1;
        if (in_w) rs1_wfix = XLEN'($signed(in_rs1[31:0]));
        min_mag   = in_w ? (XLEN'(1) << 31) : (XLEN'(1) << (XLEN - 1));
        ovf       = rs1_neg && rs2_neg && (rs1_mag == min_mag) && (rs2_mag == XLEN'(1));
        early_hit = (op_is_mul(in_op) && (rs1_mag == '0 || rs2_mag == '0)) ||
                    (op_is_div(in_op) && (div_zero || ovf));
        early_res = '0;
        if (op_is_div(in_op)) begin
            if (div_zero) early_res = op_is_rem(in_op) ? rs1_wfix : '1;
            else          early_res = op_is_rem(in_op) ? '0 : rs1_wfix;
        end
        early_now = early_hit || !(op_is_mul(in_op) || op_is_div(in_op));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            early_hit_q <= early_hit;
            early_res_q <= early_res;
        end
    end
`else
    assign early_now = !(op_is_mul(in_op) || op_is_div(in_op));
`endif

    // Multiplier on the low half is consumed LSB-first; the high half accumulates.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= in_op;
            s1_q       <= rs1_neg;
            s2_q       <= rs2_neg;
            div_zero_q <= div_zero;
            early_q    <= early_now;
            mcand_q    <= rs1_mag;
            acc_q      <= {{XLEN{1'b0}}, rs2_mag};
        end else if (step) begin
            acc_q <= {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    md_iter_divider #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .step      (step),
        .w         (in_w),
        .dividend  (rs1_mag),
        .divisor   (rs2_mag),
        .quotient  (quo),
        .remainder (rem),
        .last      (div_last)
    );

    // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
    always_comb begin
        prod     = (s1_q ^ s2_q) ? -acc_q : acc_q;
        quo_s    = ((s1_q ^ s2_q) && !div_zero_q) ? -quo : quo;
        rem_s    = s1_q ? -rem : rem;
        res_next = '0;
        case (op_q)
            MD_OP_MUL:                              res_next = prod[XLEN-1:0];
            MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU:  res_next = prod[2*XLEN-1:XLEN];
            MD_OP_MULW:                             res_next = XLEN'($signed(acc_q[XLEN-32 +: 32]));
            MD_OP_DIV, MD_OP_DIVU:                  res_next = quo_s;
            MD_OP_REM, MD_OP_REMU:                  res_next = rem_s;
            MD_OP_DIVW, MD_OP_DIVUW:                res_next = XLEN'($signed(quo_s[31:0]));
            MD_OP_REMW, MD_OP_REMUW:                res_next = XLEN'($signed(rem_s[31:0]));
            default:                                res_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_ST_IDLE: if (accept) state_next = MD_ST_CALC;
            MD_ST_CALC: begin
                if (flush)                    state_next = MD_ST_IDLE;
                else if (early_q || div_last) state_next = MD_ST_DONE;
            end
            MD_ST_DONE: if (flush || out_ready) state_next = MD_ST_IDLE;
            default:    state_next = MD_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == MD_ST_IDLE);
        out_valid = (state == MD_ST_DONE);
        busy      = (state != MD_ST_IDLE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_result <= '0;
        end else if (state == MD_ST_CALC && state_next == MD_ST_DONE) begin
`ifdef MULDIV_EARLY_OUT_EN
            out_result <= early_hit_q ? early_res_q : res_next;
`else
            out_result <= res_next;
`endif
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed plus randomized checks of exe_muldiv_unit against an arithmetic reference model.
module tb_exe_muldiv_unit;
  import exe_muldiv_unit_pkg::*;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [3:0]  in_op;
  logic [63:0] in_rs1, in_rs2, out_result;
  logic        in_ready, out_valid, busy;
  md_state_e   dbg_state;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  exe_muldiv_unit #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: the RV64M arithmetic rules written directly.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32, b32, t;
    logic [63:0]  r;
    a32 = a[31:0];
    b32 = b[31:0];
    r = '0;
    case (op)
      4'd0: r = a * b;
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
      4'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
      4'd4: begin
        if (b == 0) r = ONES;
        else if (a == MIN64 && b == ONES) r = a;
        else r = $signed(a) / $signed(b);
      end
      4'd5: begin if (b == 0) r = ONES; else r = a / b; end
      4'd6: begin
        if (b == 0) r = a;
        else if (a == MIN64 && b == ONES) r = 0;
        else r = $signed(a) % $signed(b);
      end
      4'd7: begin if (b == 0) r = a; else r = a % b; end
      4'd8: begin t = a32 * b32; r = sx32(t); end
      4'd9: begin
        if (b32 == 0) t = 32'hFFFF_FFFF;
        else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) t = a32;
        else t = $signed(a32) / $signed(b32);
        r = sx32(t);
      end
      4'd10: begin if (b32 == 0) t = 32'hFFFF_FFFF; else t = a32 / b32; r = sx32(t); end
      4'd11: begin
        if (b32 == 0) t = a32;
        else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) t = 0;
        else t = $signed(a32) % $signed(b32);
        r = sx32(t);
      end
      4'd12: begin if (b32 == 0) t = a32; else t = a32 % b32; r = sx32(t); end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic w, is_mul, is_div, is_signed;
    w         = op inside {4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    is_mul    = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    is_div    = op inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};
    is_signed = op inside {4'd4, 4'd6, 4'd9, 4'd11};
    if (!is_mul && !is_div) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (is_mul && (w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0))) return 1;
    if (is_div && (w ? b[31:0] == 0 : b == 0)) return 1;
    if (is_div && is_signed && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                  : (a == MIN64 && b == ONES))) return 1;
`else
    if (is_signed && a == ONES && b == ONES) return w ? 33 : 65;
`endif
    return w ? 33 : 65;
  endfunction

  // Offers one op, waits (bounded) for out_valid and checks latency and result; leaves DONE held.
  task automatic issue_wait(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int k;
    int lat;
    exp_q.push_back(model(op, a, b));
    lat = lat_of(op, a, b);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("busy_after_accept op%0d", op), busy, 1);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("latency op%0d", op), k, lat);
    check($sformatf("result op%0d a=%h b=%h", op, a, b), out_result, exp_q[0]);
  endtask

  task automatic release_result(input int hold);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
    issue_wait(op, a, b);
    release_result(hold);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    int          sel;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_result", out_result, 0);
    check("reset_busy", busy, 0);
    check("reset_state", 64'(dbg_state), 64'(MD_ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(MD_OP_MUL, 64'd7, -64'sd3, 3);
    do_op(MD_OP_MULHU, ONES, ONES, 0);
    do_op(MD_OP_MULH, ONES, ONES, 0);
    do_op(MD_OP_DIV, -64'sd20, 64'd3, 1);
    do_op(MD_OP_REM, -64'sd20, 64'd3, 0);
    do_op(MD_OP_DIVU, 64'd20, 64'd3, 0);
    do_op(MD_OP_REMU, 64'd20, 64'd3, 0);
    do_op(MD_OP_DIV, 64'd5, 64'd0, 0);
    do_op(MD_OP_REM, 64'd5, 64'd0, 0);
    do_op(MD_OP_DIV, MIN64, ONES, 0);
    do_op(MD_OP_REM, MIN64, ONES, 0);
    do_op(MD_OP_DIVUW, 64'h1_FFFF_FFFE, 64'd1, 0);
    do_op(MD_OP_MULW, 64'h4000_0000, 64'd2, 0);
    do_op(4'd13, 64'h1234, 64'h5678, 1);

    // flush in the middle of a divide
    in_valid = 1'b1; in_op = MD_OP_DIV; in_rs1 = 64'd100; in_rs2 = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_in_ready", in_ready, 1);
    check("flush_calc_busy", busy, 0);
    watch_quiet("flush_calc_no_valid", 70);
    do_op(MD_OP_DIV, 64'd9, 64'd3, 0);

    // flush while a result is held
    issue_wait(MD_OP_DIVU, 64'd1000, 64'd10);
    void'(exp_q.pop_front());
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_valid", out_valid, 0);
    check("flush_done_in_ready", in_ready, 1);

    // flush wins over an offer in IDLE
    in_valid = 1'b1; in_op = MD_OP_MUL; in_rs1 = 64'd3; in_rs2 = 64'd4; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", busy, 0);
    watch_quiet("flush_idle_no_valid", 70);

    // reset while DONE, then reset mid-CALC
    issue_wait(MD_OP_MUL, 64'd123, 64'd456);
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_valid", out_valid, 0);
    check("rst_done_result", out_result, 0);
    check("rst_done_in_ready", in_ready, 1);
    in_valid = 1'b1; in_op = MD_OP_REMU; in_rs1 = 64'd77; in_rs2 = 64'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_calc_busy", busy, 0);
    check("rst_calc_result", out_result, 0);
    watch_quiet("rst_calc_no_valid", 70);

    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(0, 12));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: begin a = MIN64; b = ONES; end
        2: a = '0;
        3: begin a[31:0] = 32'h8000_0000; b[31:0] = 32'hFFFF_FFFF; end
        4: b = 64'($urandom_range(1, 20));
        5: begin a = 64'($urandom_range(0, 1000)); b = -64'($urandom_range(1, 9)); end
        default: ;
      endcase
      do_op(op, a, b, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
